// File: rtl/controller_sequencer.sv
// SAP-1 controller/sequencer: a six-state one-hot ring counter (T1..T6) and an
// opcode decoder that together drive the 12-bit control word for every bus agent.
// All state, including the control word, changes on the falling edge of CLK.
// This keeps the word stable across the rising edge, where the datapath samples it.
//
// Ports:
//   CLK      in   system clock, state updates on negedge
//   CLR_bar  in   asynchronous active-low reset
//   opcode   in   IR upper nibble, sampled when leaving T3
//   T        out  one-hot ring state, T[0]=T1 .. T[5]=T6
//   Cp, Ep   out  PC increment / PC drives W bus
//   Lm_bar   out  MAR load (active low)
//   CE_bar   out  RAM drives W bus (active low)
//   Li_bar   out  IR load (active low)
//   Ei_bar   out  IR low nibble drives W bus (active low)
//   La_bar   out  A load (active low)
//   Ea       out  A drives W bus
//   Su, Eu   out  ALU subtract select / ALU drives W bus
//   Lb_bar   out  B load (active low)
//   Lo_bar   out  OUT load (active low)
//   HLT      out  halted flag
module controller_sequencer #(
  parameter bit         SKIP_IDLE   = 1'b0,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic       CLK,
  input  logic       CLR_bar,
  input  logic [3:0] opcode,
  output logic [5:0] T,
  output logic       Cp,
  output logic       Ep,
  output logic       Lm_bar,
  output logic       CE_bar,
  output logic       Li_bar,
  output logic       Ei_bar,
  output logic       La_bar,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb_bar,
  output logic       Lo_bar,
  output logic       HLT
);

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'h0);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'h1);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'h2);
  localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'hE);

  typedef enum logic [5:0] {
    S_T1 = 6'b000001,
    S_T2 = 6'b000010,
    S_T3 = 6'b000100,
    S_T4 = 6'b001000,
    S_T5 = 6'b010000,
    S_T6 = 6'b100000
  } state_t;

  typedef struct packed {
    logic cp;
    logic ep;
    logic lm_bar;
    logic ce_bar;
    logic li_bar;
    logic ei_bar;
    logic la_bar;
    logic ea;
    logic su;
    logic eu;
    logic lb_bar;
    logic lo_bar;
  } ctrl_t;

  // Every agent idle: enables low, active-low strobes high.
  localparam ctrl_t CTRL_IDLE = ctrl_t'(12'b0011_1110_0011);

  state_t          state, state_n;
  logic [OP_W-1:0] op, op_n;
  logic            hlt_q, hlt_n;
  ctrl_t           ctrl, ctrl_n;

  // Control word for a given state under a given latched opcode.
  function automatic ctrl_t decode(input state_t s, input logic [OP_W-1:0] o);
    ctrl_t c;
    c = CTRL_IDLE;
    unique case (s)
      S_T1: begin c.ep = 1'b1; c.lm_bar = 1'b0; end
      S_T2: c.cp = 1'b1;
      S_T3: begin c.ce_bar = 1'b0; c.li_bar = 1'b0; end
      S_T4: begin
        if (o == OP_LDA || o == OP_ADD || o == OP_SUB) begin
          c.ei_bar = 1'b0;
          c.lm_bar = 1'b0;
        end else if (o == OP_OUT) begin
          c.ea     = 1'b1;
          c.lo_bar = 1'b0;
        end
      end
      S_T5: begin
        if (o == OP_LDA) begin
          c.ce_bar = 1'b0;
          c.la_bar = 1'b0;
        end else if (o == OP_ADD || o == OP_SUB) begin
          c.ce_bar = 1'b0;
          c.lb_bar = 1'b0;
        end
      end
      S_T6: begin
        if (o == OP_ADD || o == OP_SUB) begin
          c.eu     = 1'b1;
          c.la_bar = 1'b0;
          c.su     = (o == OP_SUB);
        end
      end
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

  // State, latched opcode, halt flag and control word share one register stage.
  always_ff @(negedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      state <= S_T1;
      op    <= OP_W'(4'h0);
      hlt_q <= 1'b0;
      ctrl  <= decode(S_T1, OP_W'(4'h0));
    end else begin
      state <= state_n;
      op    <= op_n;
      hlt_q <= hlt_n;
      ctrl  <= ctrl_n;
    end
  end

  // Ring advance; the next control word is decoded from the next state so it
  // lands in the register together with T.
  always_comb begin
    state_n = state;
    op_n    = op;
    hlt_n   = hlt_q;
    if (!hlt_q) begin
      unique case (state)
        S_T1: state_n = S_T2;
        S_T2: state_n = S_T3;
        S_T3: begin
          op_n = opcode;
          if (opcode == HALT_OPCODE) begin
            state_n = S_T4;
            hlt_n   = 1'b1;
          end else if (SKIP_IDLE && opcode != OP_LDA && opcode != OP_ADD &&
                       opcode != OP_SUB && opcode != OP_OUT) begin
            state_n = S_T1;
          end else begin
            state_n = S_T4;
          end
        end
        S_T4: state_n = (SKIP_IDLE && op == OP_OUT) ? S_T1 : S_T5;
        S_T5: state_n = (SKIP_IDLE && op == OP_LDA) ? S_T1 : S_T6;
        S_T6: state_n = S_T1;
        default: state_n = S_T1;
      endcase
    end
    ctrl_n = hlt_n ? CTRL_IDLE : decode(state_n, op_n);
  end

  assign T      = state;
  assign HLT    = hlt_q;
  assign Cp     = ctrl.cp;
  assign Ep     = ctrl.ep;
  assign Lm_bar = ctrl.lm_bar;
  assign CE_bar = ctrl.ce_bar;
  assign Li_bar = ctrl.li_bar;
  assign Ei_bar = ctrl.ei_bar;
  assign La_bar = ctrl.la_bar;
  assign Ea     = ctrl.ea;
  assign Su     = ctrl.su;
  assign Eu     = ctrl.eu;
  assign Lb_bar = ctrl.lb_bar;
  assign Lo_bar = ctrl.lo_bar;

endmodule

// File: tb/tb_controller_sequencer.sv
// Testbench for controller_sequencer. Two instances are exercised in turn, one
// with SKIP_IDLE=0 and one with SKIP_IDLE=1. Stimulus queues the expected word
// for each upcoming state; a monitor compares it on the rising edge.
module tb_controller_sequencer;

  logic       CLK;
  logic       clr_s    [2];
  logic [3:0] opcode_s [2];

  logic [5:0] t_o  [2];
  logic cp_o [2], ep_o [2], lm_o [2], ce_o [2], li_o [2], ei_o [2];
  logic la_o [2], ea_o [2], su_o [2], eu_o [2], lb_o [2], lo_o [2], hlt_o [2];

  // {T, HLT, Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar}
  logic [18:0] obs [2];
  logic [18:0] exp_q [$];

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cur      = 0;
  bit  mon_en   = 1'b0;

  controller_sequencer #(.SKIP_IDLE(1'b0), .HALT_OPCODE(4'hF)) dut0 (
    .CLK(CLK), .CLR_bar(clr_s[0]), .opcode(opcode_s[0]), .T(t_o[0]),
    .Cp(cp_o[0]), .Ep(ep_o[0]), .Lm_bar(lm_o[0]), .CE_bar(ce_o[0]),
    .Li_bar(li_o[0]), .Ei_bar(ei_o[0]), .La_bar(la_o[0]), .Ea(ea_o[0]),
    .Su(su_o[0]), .Eu(eu_o[0]), .Lb_bar(lb_o[0]), .Lo_bar(lo_o[0]), .HLT(hlt_o[0])
  );

  controller_sequencer #(.SKIP_IDLE(1'b1), .HALT_OPCODE(4'hF)) dut1 (
    .CLK(CLK), .CLR_bar(clr_s[1]), .opcode(opcode_s[1]), .T(t_o[1]),
    .Cp(cp_o[1]), .Ep(ep_o[1]), .Lm_bar(lm_o[1]), .CE_bar(ce_o[1]),
    .Li_bar(li_o[1]), .Ei_bar(ei_o[1]), .La_bar(la_o[1]), .Ea(ea_o[1]),
    .Su(su_o[1]), .Eu(eu_o[1]), .Lb_bar(lb_o[1]), .Lo_bar(lo_o[1]), .HLT(hlt_o[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_obs
    assign obs[g] = {t_o[g], hlt_o[g], cp_o[g], ep_o[g], lm_o[g], ce_o[g], li_o[g],
                     ei_o[g], la_o[g], ea_o[g], su_o[g], eu_o[g], lb_o[g], lo_o[g]};
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected outputs for step t (1..6) of an instruction, straight from the
  // per-instruction micro-step table.
  function automatic logic [18:0] exp_word(input int t, input logic [3:0] op, input bit halted);
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
    logic [5:0] th;
    cp = 0; ep = 0; ea = 0; su = 0; eu = 0;
    lm = 1; ce = 1; li = 1; ei = 1; la = 1; lb = 1; lo = 1;
    if (!halted) begin
      case (t)
        1: begin ep = 1; lm = 0; end
        2: cp = 1;
        3: begin ce = 0; li = 0; end
        4: begin
          if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin ei = 0; lm = 0; end
          else if (op == 4'hE) begin ea = 1; lo = 0; end
        end
        5: begin
          if (op == 4'h0) begin ce = 0; la = 0; end
          else if (op == 4'h1 || op == 4'h2) begin ce = 0; lb = 0; end
        end
        6: begin
          if (op == 4'h1 || op == 4'h2) begin eu = 1; la = 0; su = (op == 4'h2); end
        end
        default: ;
      endcase
    end
    th = halted ? 6'b001000 : 6'(1 << (t - 1));
    return {th, halted, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
  endfunction

  // Number of T-states an instruction occupies.
  function automatic int instr_len(input logic [3:0] op, input bit skip);
    if (!skip) return 6;
    if (op == 4'h0) return 5;
    if (op == 4'hE) return 4;
    if (op == 4'h1 || op == 4'h2) return 6;
    return 3;
  endfunction

  function automatic logic [3:0] pick_op(input int n);
    logic [3:0] tbl [4];
    tbl[0] = 4'h0; tbl[1] = 4'h1; tbl[2] = 4'h2; tbl[3] = 4'hE;
    if (n < 4) return tbl[n];
    if (n == 4) return 4'h3;
    if ($urandom_range(0, 4) == 0) return 4'($urandom_range(3, 13));
    return tbl[$urandom_range(0, 3)];
  endfunction

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (inst %0d, t=%0t)", name, act, expv, cur, $time);
    end
  endtask

  task automatic check_le(input string name, input int act, input int lim);
    n_checks++;
    if (act > lim) begin
      n_fail++;
      $display("FAIL %s: got %0d expected <= %0d (inst %0d, t=%0t)", name, act, lim, cur, $time);
    end
  endtask

  // Monitor: compares the presented state against the queued expectation.
  always @(posedge CLK) begin
    if (mon_en) begin
      logic [18:0] o;
      int drv, ld;
      o = obs[cur];
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got empty queue expected an entry (t=%0t)", $time);
      end else begin
        check("ctrl_word", o, exp_q.pop_front());
      end
      drv = int'(o[10]) + int'(!o[8]) + int'(!o[6]) + int'(o[4]) + int'(o[2]);
      ld  = int'(!o[9]) + int'(!o[7]) + int'(!o[5]) + int'(!o[1]) + int'(!o[0]);
      check_le("bus_drivers", drv, 1);
      check_le("load_strobes", ld, 1);
      n_checks++;
      if (!$onehot(o[18:13])) begin
        n_fail++;
        $display("FAIL t_onehot: got %b expected one-hot (t=%0t)", o[18:13], $time);
      end
    end
  end

  // Reset the selected instance, then run random instructions through it.
  task automatic run_phase(input int sel, input bit skip, input int n_instr);
    logic [3:0] op;
    int len;
    mon_en = 1'b0;
    exp_q.delete();
    cur = sel;
    clr_s[sel] = 1'b0;
    @(posedge CLK); #1;
    check("reset_state", obs[sel], exp_word(1, 4'h0, 1'b0));
    clr_s[sel] = 1'b1;
    mon_en = 1'b1;
    for (int n = 0; n < n_instr; n++) begin
      op  = pick_op(n);
      len = instr_len(op, skip);
      for (int i = 0; i < len; i++) begin
        opcode_s[sel] = (i == 2) ? op : 4'($urandom);
        if (i + 1 < len) exp_q.push_back(exp_word(i + 2, op, 1'b0));
        else             exp_q.push_back(exp_word(1, op, 1'b0));
        @(posedge CLK); #1;
      end
    end
  endtask

  // LDA up to T5, then an asynchronous clear checked before the next edge.
  task automatic mid_reset_lda(input int sel);
    for (int i = 0; i < 4; i++) begin
      opcode_s[sel] = (i == 2) ? 4'h0 : 4'($urandom);
      exp_q.push_back(exp_word(i + 2, 4'h0, 1'b0));
      @(posedge CLK); #1;
    end
    clr_s[sel] = 1'b0;
    #1;
    check("async_reset_mid_t5", obs[sel], exp_word(1, 4'h0, 1'b0));
    mon_en = 1'b0;
    exp_q.delete();
  endtask

  // Halt opcode, 20 frozen clocks, then a clear pulse.
  task automatic halt_test(input int sel);
    for (int i = 0; i < 3; i++) begin
      opcode_s[sel] = (i == 2) ? 4'hF : 4'($urandom);
      if (i < 2) exp_q.push_back(exp_word(i + 2, 4'h0, 1'b0));
      else       exp_q.push_back(exp_word(4, 4'hF, 1'b1));
      @(posedge CLK); #1;
    end
    repeat (20) begin
      opcode_s[sel] = 4'($urandom);
      exp_q.push_back(exp_word(4, 4'hF, 1'b1));
      @(posedge CLK); #1;
    end
    mon_en = 1'b0;
    exp_q.delete();
    clr_s[sel] = 1'b0;
    #1;
    check("halt_cleared", obs[sel], exp_word(1, 4'h0, 1'b0));
    @(posedge CLK); #1;
    clr_s[sel] = 1'b1;
  endtask

  initial begin
    clr_s[0] = 1'b1;
    clr_s[1] = 1'b1;
    opcode_s[0] = 4'h0;
    opcode_s[1] = 4'h0;
    #2;
    clr_s[0] = 1'b0;
    clr_s[1] = 1'b0;
    run_phase(0, 1'b0, 25);
    mid_reset_lda(0);
    run_phase(0, 1'b0, 10);
    halt_test(0);
    run_phase(1, 1'b1, 40);
    mid_reset_lda(1);
    run_phase(1, 1'b1, 10);
    halt_test(1);
    mon_en = 1'b0;
    @(posedge CLK); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
